dro_bank_scheduler: RTL

Clocked controller that shares a bank of NCELL destructive-readout (DRO) storage cells between NREQ requesters. It arbitrates write (set) and read (readout) requests round-robin and emits toggle-encoded SFQ pulses (one output transition = one pulse) on per-cell set/readout lines. It enforces a minimum pulse spacing per cell that covers the DRO set/readout hold constraints, detects the cell's output pulse to return read data, and keeps a shadow copy of every cell's state for consistency checking.

---
 rtl/dro_bank_scheduler_pkg.sv | 30 +++
 rtl/dro_bank_scheduler_rr_arbiter.sv | 40 ++++
 rtl/dro_bank_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dro_bank_scheduler_pkg.sv
// +--------------------------------------------------------------------+
// | dro_sched_pkg : shared types and width helpers for the DRO bank     |
// | scheduler.                                           Revision: 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package dro_sched_pkg;

   typedef enum logic {
      OP_SET  = 1'b0,
      OP_READ = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } state_e;

   function automatic int addr_width(input int ncell);
      return (ncell > 1) ? $clog2(ncell) : 1;
   endfunction

   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dro_bank_scheduler_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : one-hot round-robin grant starting at ptr.             |
// |                                                      Revision: 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
   import dro_sched_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant
);

   logic found;

   // First pass covers ptr..NREQ-1, second pass wraps around to 0.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req[j] && (IDW'(j) >= ptr)) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dro_bank_scheduler.sv
// +--------------------------------------------------------------------+
// | dro_bank_scheduler : round-robin set/readout scheduler for a bank   |
// | of DRO cells with shadow-state consistency checking. Revision: 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module dro_bank_scheduler
   import dro_sched_pkg::*;
#(
   parameter  int NREQ    = 2,
   parameter  int NCELL   = 4,
   parameter  int GAP_CYC = 2,
   parameter  int RD_LAT  = 3,
   localparam int AW      = addr_width(NCELL),
   localparam int IDW     = id_width(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*AW-1:0]   req_addr,
   output logic [NREQ-1:0]      req_ready,
   output logic [NCELL-1:0]     set_tgl,
   output logic [NCELL-1:0]     rd_tgl,
   input  logic [NCELL-1:0]     dout_tgl,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_data,
   output logic                 err
);

   localparam int CDW  = $clog2(GAP_CYC + 1);
   localparam int CNTW = $clog2(RD_LAT + 1);
   localparam logic [CDW-1:0]  GAP_VAL = CDW'(GAP_CYC);
   localparam logic [CNTW-1:0] LAT_VAL = CNTW'(RD_LAT);

   state_e            state_q, state_d;
   logic [NCELL-1:0]  set_tgl_q, set_tgl_d;
   logic [NCELL-1:0]  rd_tgl_q, rd_tgl_d;
   logic [NCELL-1:0]  shadow_q, shadow_d;
   logic [NCELL-1:0]  known_q, known_d;
   logic [CDW-1:0]    cool_q [NCELL];
   logic [CDW-1:0]    cool_d [NCELL];
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [AW-1:0]     rd_cell_q, rd_cell_d;
   logic [IDW-1:0]    rd_id_q, rd_id_d;
   logic              snap_q, snap_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic              rsp_data_q, rsp_data_d;
   logic              err_q, err_d;
   logic [NCELL-1:0]  dout_prev_q;

   logic [AW-1:0]     addr_w [NREQ];
   logic [NREQ-1:0]   elig;
   logic [NREQ-1:0]   grant;
   logic [AW-1:0]     g_addr;
   logic              rsp_bit;

   // Reads only start from IDLE; writes are held off the cell under readout.
   for (genvar i = 0; i < NREQ; i++) begin : g_elig
      assign addr_w[i] = req_addr[i*AW +: AW];
      assign elig[i]   = req_valid[i] && (cool_q[addr_w[i]] == '0) &&
                         ((state_q == ST_IDLE) ||
                          ((req_op[i] == OP_SET) && (addr_w[i] != rd_cell_q)));
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (elig),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   assign req_ready = reset ? '0 : grant;

   always_comb begin
      state_d     = state_q;
      set_tgl_d   = set_tgl_q;
      rd_tgl_d    = rd_tgl_q;
      shadow_d    = shadow_q;
      known_d     = known_q;
      rr_ptr_d    = rr_ptr_q;
      rd_cell_d   = rd_cell_q;
      rd_id_d     = rd_id_q;
      snap_d      = snap_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      err_d       = err_q;
      g_addr      = '0;
      rsp_bit     = dout_tgl[rd_cell_q] ^ snap_q;

      for (int c = 0; c < NCELL; c++) begin
         cool_d[c] = (cool_q[c] != '0) ? cool_q[c] - 1'b1 : cool_q[c];
      end

      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_addr         = addr_w[i];
            rr_ptr_d       = IDW'((i + 1) % NREQ);
            cool_d[g_addr] = GAP_VAL;
            if (req_op[i] == OP_SET) begin
               set_tgl_d[g_addr] = ~set_tgl_q[g_addr];
               shadow_d[g_addr]  = 1'b1;
               known_d[g_addr]   = 1'b1;
            end else begin
               rd_tgl_d[g_addr] = ~rd_tgl_q[g_addr];
               rd_cell_d        = g_addr;
               rd_id_d          = IDW'(i);
               snap_d           = dout_tgl[g_addr];
               cnt_d            = LAT_VAL;
               state_d          = ST_RD_WAIT;
            end
         end
      end

      case (state_q)
         ST_RD_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNTW'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = rd_id_q;
            rsp_data_d  = rsp_bit;
            if (known_q[rd_cell_q] && (rsp_bit != shadow_q[rd_cell_q])) begin
               err_d = 1'b1;
            end
            shadow_d[rd_cell_q] = 1'b0;
            known_d[rd_cell_q]  = 1'b1;
            state_d             = ST_IDLE;
         end
         default: ;
      endcase

      // Output edges are only legal on the cell currently under readout.
      for (int c = 0; c < NCELL; c++) begin
         if ((dout_tgl[c] != dout_prev_q[c]) &&
             ((state_q == ST_IDLE) || (AW'(c) != rd_cell_q))) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         set_tgl_q   <= '0;
         rd_tgl_q    <= '0;
         shadow_q    <= '0;
         known_q     <= '0;
         rr_ptr_q    <= '0;
         rd_cell_q   <= '0;
         rd_id_q     <= '0;
         snap_q      <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= 1'b0;
         err_q       <= 1'b0;
         for (int c = 0; c < NCELL; c++) begin
            cool_q[c] <= '0;
         end
      end else begin
         state_q     <= state_d;
         set_tgl_q   <= set_tgl_d;
         rd_tgl_q    <= rd_tgl_d;
         shadow_q    <= shadow_d;
         known_q     <= known_d;
         rr_ptr_q    <= rr_ptr_d;
         rd_cell_q   <= rd_cell_d;
         rd_id_q     <= rd_id_d;
         snap_q      <= snap_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
         for (int c = 0; c < NCELL; c++) begin
            cool_q[c] <= cool_d[c];
         end
      end
   end

   // Tracks the line level through reset so a held-high output is not an edge.
   always_ff @(posedge clk) begin
      dout_prev_q <= dout_tgl;
   end

   assign set_tgl   = set_tgl_q;
   assign rd_tgl    = rd_tgl_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign err       = err_q;

endmodule

`default_nettype wire
